// File: rtl/vga_pkg.sv
// Frame-buffer geometry and state encoding shared by the VRAM drawing engine.
package vga_pkg;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = X_W + Y_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLIP   = 2'd1,
    ST_FILL   = 2'd2,
    ST_FINISH = 2'd3
  } fill_state_t;
endpackage

// File: rtl/vram_rect_fill_clip.sv
// Clips the bottom-right corner of a rectangle to the frame buffer and flags empty results.
module rect_clip #(
  parameter int FB_W = vga_pkg::FB_W,
  parameter int FB_H = vga_pkg::FB_H,
  parameter int X_W  = vga_pkg::X_W,
  parameter int Y_W  = vga_pkg::Y_W
) (
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x1_clip,
  output logic [Y_W-1:0] y1_clip,
  output logic           reject
);
  import vga_pkg::*;

  localparam logic [X_W-1:0] X_MAX = X_W'(FB_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(FB_H - 1);

  // Rejection is judged against the clipped corner, so an off-screen
  // origin and an inverted rectangle fall out the same way.
  always_comb begin
    x1_clip = (x1 > X_MAX) ? X_MAX : x1;
    y1_clip = (y1 > Y_MAX) ? Y_MAX : y1;
    reject  = (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1_clip) || (y0 > y1_clip);
  end
endmodule

// File: rtl/vram_rect_fill.sv
// Filled-rectangle engine: writes one pixel per accepted VRAM cycle in raster order.
module vram_rect_fill #(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int X_W         = vga_pkg::X_W,
  parameter int Y_W         = vga_pkg::Y_W,
  parameter int COLOR_W     = vga_pkg::COLOR_W,
  parameter bit VBLANK_ONLY = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [X_W-1:0]       cmd_x0,
  input  logic [Y_W-1:0]       cmd_y0,
  input  logic [X_W-1:0]       cmd_x1,
  input  logic [Y_W-1:0]       cmd_y1,
  input  logic [COLOR_W-1:0]   cmd_color,
  input  logic                 abort,
  input  logic                 vblank,
  output logic                 wr_en,
  output logic [X_W+Y_W-1:0]   wr_addr,
  output logic [COLOR_W-1:0]   wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  import vga_pkg::*;

  fill_state_t state, state_nxt;

  logic [X_W-1:0]     x0_r, x1_r, cur_x, x1_clip;
  logic [Y_W-1:0]     y0_r, y1_r, cur_y, y1_clip;
  logic [COLOR_W-1:0] color_r;
  logic               reject, wr_pend, accept, row_end, last_px;
  logic               wr_pend_nxt, busy_nxt, done_nxt, err_nxt;

  rect_clip #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .X_W  (X_W),
    .Y_W  (Y_W)
  ) u_clip (
    .x0      (x0_r),
    .y0      (y0_r),
    .x1      (x1_r),
    .y1      (y1_r),
    .x1_clip (x1_clip),
    .y1_clip (y1_clip),
    .reject  (reject)
  );

  // vblank gates the registered strobe directly so that no write can leak
  // into active video in the cycle vblank falls.
  assign wr_en     = wr_pend & (~VBLANK_ONLY | vblank);
  assign accept    = wr_en & wr_ready;
  assign row_end   = (cur_x == x1_r);
  assign last_px   = row_end && (cur_y == y1_r);
  assign cmd_ready = (state == ST_IDLE);
  assign wr_addr   = {cur_y, cur_x};
  assign wr_data   = color_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      wr_pend <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_pend <= wr_pend_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wr_pend_nxt = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = ST_CLIP;
          busy_nxt  = 1'b1;
        end
      end
      ST_CLIP: begin
        if (abort || reject) begin
          state_nxt = ST_FINISH;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else begin
          state_nxt   = ST_FILL;
          busy_nxt    = 1'b1;
          wr_pend_nxt = 1'b1;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_nxt = ST_FINISH;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else if (accept && last_px) begin
          state_nxt = ST_FINISH;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt    = 1'b1;
          wr_pend_nxt = 1'b1;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, clip write-back and raster stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_r    <= '0;
      y0_r    <= '0;
      x1_r    <= '0;
      y1_r    <= '0;
      color_r <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            x0_r    <= cmd_x0;
            y0_r    <= cmd_y0;
            x1_r    <= cmd_x1;
            y1_r    <= cmd_y1;
            color_r <= cmd_color;
          end
        end
        ST_CLIP: begin
          x1_r  <= x1_clip;
          y1_r  <= y1_clip;
          cur_x <= x0_r;
          cur_y <= y0_r;
        end
        ST_FILL: begin
          if (accept && !last_px) begin
            if (row_end) begin
              cur_x <= x0_r;
              cur_y <= cur_y + Y_W'(1);
            end else begin
              cur_x <= cur_x + X_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_rect_fill.sv
// Randomized bench for vram_rect_fill against a raster-order rectangle model.
module tb_vram_rect_fill;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_x0 = '0, cmd_x1 = '0;
  logic [6:0]  cmd_y0 = '0, cmd_y1 = '0;
  logic [2:0]  cmd_color = '0;
  logic        abort = 1'b0;
  logic        vblank = 1'b1;
  logic        wr_ready = 1'b1;

  logic        cmd_ready_0, wr_en_0, busy_0, done_0, err_0;
  logic [14:0] wr_addr_0;
  logic [2:0]  wr_data_0;
  logic        cmd_ready_v, wr_en_v, busy_v, done_v, err_v;
  logic [14:0] wr_addr_v;
  logic [2:0]  wr_data_v;

  int total = 0;
  int bad = 0;

  logic [14:0] got_addr[$];
  logic [2:0]  got_data[$];
  int          exp_addr[$];
  int          first_wr, done_at, abort_s, unstable, vb_bad;
  logic        done_err, done_busy;

  always #5 clk = ~clk;

  vram_rect_fill #(.VBLANK_ONLY(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_0),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .abort(abort), .vblank(vblank), .wr_en(wr_en_0),
    .wr_addr(wr_addr_0), .wr_data(wr_data_0), .wr_ready(wr_ready),
    .busy(busy_0), .done(done_0), .err(err_0)
  );

  vram_rect_fill #(.VBLANK_ONLY(1'b1)) dut_vb (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_v),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .abort(abort), .vblank(vblank), .wr_en(wr_en_v),
    .wr_addr(wr_addr_v), .wr_data(wr_data_v), .wr_ready(wr_ready),
    .busy(busy_v), .done(done_v), .err(err_v)
  );

  // Reference: clip to the 160x120 frame, reject empty rectangles, list pixels row by row.
  task automatic model(input int x0, input int y0, input int x1, input int y1, output bit rej);
    int cx1, cy1;
    cx1 = (x1 > 159) ? 159 : x1;
    cy1 = (y1 > 119) ? 119 : y1;
    rej = (x0 >= 160) || (y0 >= 120) || (x0 > cx1) || (y0 > cy1);
    exp_addr.delete();
    if (!rej)
      for (int y = y0; y <= cy1; y++)
        for (int x = x0; x <= cx1; x++)
          exp_addr.push_back(y * 256 + x);
  endtask

  task automatic issue_cmd(input logic [7:0] x0, input logic [6:0] y0, input logic [7:0] x1,
                           input logic [6:0] y1, input logic [2:0] c, output logic rdy);
    @(negedge clk);
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
    cmd_valid = 1'b1;
    wr_ready = 1'b1;
    abort = 1'b0;
    #1 rdy = cmd_ready_0;
  endtask

  // Observes one command from the selected instance; sample index 1 is the cycle after acceptance.
  task automatic collect(input bit sel, input int budget, input bit rnd_ready, input bit rnd_vb,
                         input int abort_after);
    bit          abort_sent, prev_stall;
    logic        en, dn;
    logic [14:0] a, pa;
    logic [2:0]  d, pd;
    got_addr.delete(); got_data.delete();
    first_wr = -1; done_at = -1; abort_s = -1; unstable = 0; vb_bad = 0;
    done_err = 1'bx; done_busy = 1'bx;
    abort_sent = 0; prev_stall = 0; pa = '0; pd = '0;
    for (int s = 1; s <= budget; s++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wr_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (rnd_vb) vblank = ($urandom_range(0, 2) == 0);
      abort = 1'b0;
      if (abort_after >= 0 && !abort_sent && got_addr.size() == abort_after) begin
        abort = 1'b1; abort_sent = 1; abort_s = s;
      end
      #1;
      en = sel ? wr_en_v : wr_en_0;
      a  = sel ? wr_addr_v : wr_addr_0;
      d  = sel ? wr_data_v : wr_data_0;
      dn = sel ? done_v : done_0;
      if (prev_stall && en && (a !== pa || d !== pd)) unstable++;
      if (sel && en && !vblank) vb_bad++;
      if (en && wr_ready) begin
        got_addr.push_back(a); got_data.push_back(d);
        if (first_wr < 0) first_wr = s;
      end
      prev_stall = en && !wr_ready;
      pa = a; pd = d;
      if (dn) begin
        done_at = s;
        done_err = sel ? err_v : err_0;
        done_busy = sel ? busy_v : busy_0;
        break;
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (cmd_ready_0 !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready_0); end
    total++; if (wr_en_0 !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_0); end
    total++; if (wr_addr_0 !== 15'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr_0); end
    total++; if (wr_data_0 !== 3'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data_0); end
    total++; if ({busy_0, done_0, err_0} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b exp=000", {busy_0, done_0, err_0}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic rdy; bit rej;
    model(10, 5, 12, 6, rej);
    issue_cmd(8'd10, 7'd5, 8'd12, 7'd6, 3'b101, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b exp=1", rdy); end
    collect(0, 60, 0, 0, -1);
    total++; if (got_addr.size() != 6) begin bad++; $display("FAIL basic_count got=%0d exp=6", got_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      total++; if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== 3'b101) begin
        bad++; $display("FAIL basic_write[%0d] got=%h/%b exp=%h/101", i, got_addr[i], got_data[i], exp_addr[i]);
      end
    end
    total++; if (first_wr != 2) begin bad++; $display("FAIL basic_first_latency got=%0d exp=2", first_wr); end
    total++; if (done_at != 8) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=8", done_at); end
    total++; if (done_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", done_err); end
    total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", done_busy); end
  endtask

  task automatic test_clip();
    logic rdy; bit rej; logic [2:0] c;
    c = 3'($urandom_range(0, 7));
    model(150, 110, 200, 127, rej);
    issue_cmd(8'd150, 7'd110, 8'd200, 7'd127, c, rdy);
    collect(0, 200, 0, 0, -1);
    total++; if (got_addr.size() != 100) begin bad++; $display("FAIL clip_count got=%0d exp=100", got_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      total++; if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== c) begin
        bad++; $display("FAIL clip_write[%0d] got=%h/%b exp=%h/%b", i, got_addr[i], got_data[i], exp_addr[i], c);
      end
    end
    total++; if (got_addr.size() == 0 || got_addr[got_addr.size()-1] !== {7'd119, 8'd159}) begin
      bad++; $display("FAIL clip_last_addr got=%h exp=%h", (got_addr.size() == 0) ? 15'h0 : got_addr[got_addr.size()-1], {7'd119, 8'd159});
    end
    total++; if (done_at != 102 || done_err !== 1'b0) begin bad++; $display("FAIL clip_done got=%0d/%b exp=102/0", done_at, done_err); end
  endtask

  task automatic test_reject();
    logic rdy;
    issue_cmd(8'd20, 7'd3, 8'd10, 7'd8, 3'b111, rdy);
    collect(0, 20, 0, 0, -1);
    total++; if (got_addr.size() != 0) begin bad++; $display("FAIL reject_inv_writes got=%0d exp=0", got_addr.size()); end
    total++; if (done_at != 2 || done_err !== 1'b1) begin bad++; $display("FAIL reject_inv_done got=%0d/%b exp=2/1", done_at, done_err); end
    issue_cmd(8'd170, 7'd3, 8'd180, 7'd8, 3'b010, rdy);
    collect(0, 20, 0, 0, -1);
    total++; if (got_addr.size() != 0) begin bad++; $display("FAIL reject_off_writes got=%0d exp=0", got_addr.size()); end
    total++; if (done_at != 2 || done_err !== 1'b1) begin bad++; $display("FAIL reject_off_done got=%0d/%b exp=2/1", done_at, done_err); end
  endtask

  task automatic test_random_rects();
    logic rdy; bit rej; logic [7:0] x0, x1; logic [6:0] y0, y1; logic [2:0] c; int exp_done;
    for (int n = 0; n < 8; n++) begin
      x0 = 8'($urandom_range(0, 170));
      x1 = 8'(x0 + 8'($urandom_range(0, 5)));
      if ($urandom_range(0, 4) == 0 && x0 > 0) x1 = x0 - 8'd1;
      y0 = 7'($urandom_range(0, 125));
      y1 = 7'(y0 + 7'($urandom_range(0, 4)));
      c  = 3'($urandom_range(0, 7));
      model(int'(x0), int'(y0), int'(x1), int'(y1), rej);
      exp_done = rej ? 2 : 2 + exp_addr.size();
      issue_cmd(x0, y0, x1, y1, c, rdy);
      collect(0, 100, 0, 0, -1);
      total++; if (got_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        total++; if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== c) begin
          bad++; $display("FAIL rand_write[%0d.%0d] got=%h/%b exp=%h/%b", n, i, got_addr[i], got_data[i], exp_addr[i], c);
        end
      end
      total++; if (done_at != exp_done || done_err !== logic'(rej)) begin
        bad++; $display("FAIL rand_done[%0d] got=%0d/%b exp=%0d/%b", n, done_at, done_err, exp_done, rej);
      end
    end
  endtask

  task automatic test_stall();
    logic rdy; bit rej; logic [7:0] x0; logic [6:0] y0; logic [2:0] c;
    for (int n = 0; n < 3; n++) begin
      x0 = 8'($urandom_range(0, 156));
      y0 = 7'($urandom_range(0, 116));
      c  = 3'($urandom_range(0, 7));
      model(int'(x0), int'(y0), int'(x0) + 3, int'(y0) + 3, rej);
      issue_cmd(x0, y0, x0 + 8'd3, y0 + 7'd3, c, rdy);
      collect(0, 300, 1, 0, -1);
      total++; if (got_addr.size() != 16) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=16", n, got_addr.size()); end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        total++; if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== c) begin
          bad++; $display("FAIL stall_write[%0d.%0d] got=%h/%b exp=%h/%b", n, i, got_addr[i], got_data[i], exp_addr[i], c);
        end
      end
      total++; if (unstable != 0) begin bad++; $display("FAIL stall_hold[%0d] changes=%0d exp=0", n, unstable); end
      total++; if (done_at < 0 || done_err !== 1'b0) begin bad++; $display("FAIL stall_done[%0d] got=%0d/%b exp=done/0", n, done_at, done_err); end
    end
  endtask

  task automatic test_vblank();
    logic rdy; bit rej; logic [2:0] c;
    c = 3'($urandom_range(0, 7));
    model(40, 20, 43, 22, rej);
    issue_cmd(8'd40, 7'd20, 8'd43, 7'd22, c, rdy);
    collect(1, 400, 0, 1, -1);
    vblank = 1'b1;
    total++; if (vb_bad != 0) begin bad++; $display("FAIL vblank_gate writes_in_active=%0d exp=0", vb_bad); end
    total++; if (got_addr.size() != 12) begin bad++; $display("FAIL vblank_count got=%0d exp=12", got_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      total++; if (int'(got_addr[i]) != exp_addr[i] || got_data[i] !== c) begin
        bad++; $display("FAIL vblank_write[%0d] got=%h/%b exp=%h/%b", i, got_addr[i], got_data[i], exp_addr[i], c);
      end
    end
    total++; if (done_at < 0 || done_err !== 1'b0) begin bad++; $display("FAIL vblank_done got=%0d/%b exp=done/0", done_at, done_err); end
  endtask

  task automatic test_abort_back_to_back();
    logic rdy; bit rej;
    model(30, 40, 33, 43, rej);
    issue_cmd(8'd30, 7'd40, 8'd33, 7'd43, 3'b011, rdy);
    collect(0, 60, 0, 0, 3);
    total++; if (got_addr.size() < 3 || got_addr.size() > 4) begin
      bad++; $display("FAIL abort_count got=%0d exp=3..4", got_addr.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      total++; if (int'(got_addr[i]) != exp_addr[i]) begin
        bad++; $display("FAIL abort_write[%0d] got=%h exp=%h", i, got_addr[i], exp_addr[i]);
      end
    end
    total++; if (abort_s < 0 || done_at != abort_s + 1 || done_err !== 1'b1) begin
      bad++; $display("FAIL abort_done got=%0d/%b exp=%0d/1", done_at, done_err, abort_s + 1);
    end
    model(7, 9, 7, 9, rej);
    issue_cmd(8'd7, 7'd9, 8'd7, 7'd9, 3'b110, rdy);
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", rdy); end
    collect(0, 20, 0, 0, -1);
    total++; if (got_addr.size() != 1 || int'(got_addr[0]) != exp_addr[0] || got_data[0] !== 3'b110) begin
      bad++; $display("FAIL b2b_single_pixel count=%0d exp=1 at %h", got_addr.size(), exp_addr[0]);
    end
    total++; if (done_at != 3 || done_err !== 1'b0) begin bad++; $display("FAIL b2b_done got=%0d/%b exp=3/0", done_at, done_err); end
  endtask

  task automatic test_reset_midfill();
    logic rdy; int seen;
    issue_cmd(8'd50, 7'd60, 8'd53, 7'd63, 3'b100, rdy);
    collect(0, 5, 0, 0, -1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (wr_en_0 !== 1'b0 || wr_en_v !== 1'b0) begin bad++; $display("FAIL rstmid_wr_en got=%b%b exp=00", wr_en_0, wr_en_v); end
    total++; if ({busy_0, done_0, err_0, cmd_ready_0} !== 4'b0001) begin
      bad++; $display("FAIL rstmid_status got=%b exp=0001", {busy_0, done_0, err_0, cmd_ready_0});
    end
    total++; if (wr_addr_0 !== 15'd0 || wr_data_0 !== 3'd0) begin
      bad++; $display("FAIL rstmid_addr_data got=%h/%b exp=0/0", wr_addr_0, wr_data_0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk); #1;
      if (done_0 || done_v || wr_en_0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done activity=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_reject();
    test_random_rects();
    test_stall();
    test_vblank();
    test_abort_back_to_back();
    test_reset_midfill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
